// File: rtl/erm16_bus_unit.sv
// Memory/I-O bus unit behind the ERM16 core: word RAM, buffered input FIFO,
// single-entry output port and a status/control register with sticky interrupt.
module erm16_bus_unit #(
  parameter int AW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR_BUS,
  input  logic [15:0] DO,
  input  logic        wrmem,
  input  logic        ioe,
  input  logic        intreq,
  output logic [15:0] DI,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq_flag
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   ram  [2**AW];
  logic [15:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          prev_ioe, prev_wr;
  logic [15:0]   prev_addr;
  logic          overflow, int_pending;

  logic [AW-1:0] maddr;
  logic          new_acc, fifo_empty, fifo_full, push, pop, flush, out_wr, ctl_wr;
  logic [15:0]   status;

  always_comb begin
    maddr      = ADDR_BUS[AW-1:0];
    // prev_ioe resets to 0, so the first I/O cycle after reset counts as new
    new_acc    = ioe && (!prev_ioe || ADDR_BUS != prev_addr || wrmem != prev_wr);
    fifo_empty = (count == '0);
    fifo_full  = (count == CW'(FIFO_DEPTH));
    in_ready   = !fifo_full;
    push       = in_valid && in_ready;
    pop        = new_acc && !wrmem && ADDR_BUS[1:0] == 2'd0 && !fifo_empty;
    out_wr     = new_acc && wrmem && ADDR_BUS[1:0] == 2'd1;
    ctl_wr     = new_acc && wrmem && ADDR_BUS[1:0] == 2'd3;
    flush      = ctl_wr && DO[2];
    status     = {8'h00, 3'(count), int_pending, overflow, out_valid, fifo_full, !fifo_empty};
    irq_flag   = int_pending;
  end

  // RAM and FIFO storage are not reset; only pointers/count define FIFO contents
  always_ff @(posedge clk) begin
    if (!ioe && wrmem) ram[maddr] <= DO;
    if (push && !flush) fifo[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DI          <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      int_pending <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      prev_ioe    <= 1'b0;
      prev_wr     <= 1'b0;
      prev_addr   <= '0;
    end else begin
      prev_ioe  <= ioe;
      prev_wr   <= wrmem;
      prev_addr <= ADDR_BUS;

      if (!ioe) DI <= ram[maddr];
      else begin
        case (ADDR_BUS[1:0])
          // address 0 keeps the captured word while the access is held
          2'd0: if (new_acc && !wrmem) DI <= fifo_empty ? 16'h0000 : fifo[rd_ptr];
          2'd1: DI <= out_data;
          2'd2: DI <= status;
          default: DI <= 16'h0000;
        endcase
      end

      if (out_wr) begin
        if (!out_valid || out_ready) begin
          out_data  <= DO;
          out_valid <= 1'b1;
        end else overflow <= 1'b1;
      end else if (out_valid && out_ready) out_valid <= 1'b0;

      if (ctl_wr && DO[1]) overflow <= 1'b0;
      if (intreq) int_pending <= 1'b1;
      else if (ctl_wr && DO[0]) int_pending <= 1'b0;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_erm16_bus_unit.sv
// Bench for erm16_bus_unit: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_erm16_bus_unit;
  localparam int AW = 8, DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] ADDR_BUS = '0, DO = '0, in_data = '0;
  logic        wrmem = 0, ioe = 0, intreq = 0, in_valid = 0, out_ready = 0;
  logic [15:0] DI, out_data;
  logic        in_ready, out_valid, irq_flag;

  erm16_bus_unit #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ADDR_BUS(ADDR_BUS), .DO(DO), .wrmem(wrmem), .ioe(ioe),
    .intreq(intreq), .DI(DI), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq_flag(irq_flag)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [15:0] m_q[$];
  logic [15:0] m_ram[int];
  logic [15:0] m_di, m_od, m_st;
  bit          m_di_ok, m_ov, m_ovf, m_int, m_new, m_rdy, m_flush;
  bit          p_ioe, p_wr;
  logic [15:0] p_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_di = 0; m_di_ok = 1; m_od = 0; m_ov = 0; m_ovf = 0; m_int = 0;
      p_ioe = 0; p_wr = 0; p_addr = 0;
    end else begin
      m_rdy   = (m_q.size() != DEPTH);
      m_new   = ioe && (!p_ioe || ADDR_BUS != p_addr || wrmem != p_wr);
      m_flush = 0;
      m_st    = 16'(m_q.size() * 32 + m_int * 16 + m_ovf * 8 + m_ov * 4 +
                    (m_q.size() == DEPTH) * 2 + (m_q.size() != 0));
      if (!ioe) begin
        if (m_ram.exists(int'(ADDR_BUS[AW-1:0]))) begin
          m_di = m_ram[int'(ADDR_BUS[AW-1:0])]; m_di_ok = 1;
        end else m_di_ok = 0;
        if (wrmem) m_ram[int'(ADDR_BUS[AW-1:0])] = DO;
      end else begin
        case (ADDR_BUS[1:0])
          2'd0: if (m_new && !wrmem) begin
                  m_di = (m_q.size() > 0) ? m_q.pop_front() : 16'h0000;
                  m_di_ok = 1;
                end
          2'd1: begin m_di = m_od; m_di_ok = 1; end
          2'd2: begin m_di = m_st; m_di_ok = 1; end
          default: begin m_di = 0; m_di_ok = 1; end
        endcase
      end
      if (m_new && wrmem && ADDR_BUS[1:0] == 2'd1) begin
        if (!m_ov || out_ready) begin m_od = DO; m_ov = 1; end
        else m_ovf = 1;
      end else if (m_ov && out_ready) m_ov = 0;
      if (m_new && wrmem && ADDR_BUS[1:0] == 2'd3) begin
        if (DO[0]) m_int = 0;
        if (DO[1]) m_ovf = 0;
        if (DO[2]) m_flush = 1;
      end
      if (intreq) m_int = 1;
      if (m_flush) m_q.delete();
      else if (in_valid && m_rdy) m_q.push_back(in_data);
      p_ioe = ioe; p_wr = wrmem; p_addr = ADDR_BUS;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_di_ok) chk("model DI", DI, m_di);
      chk("model out_data", out_data, m_od);
      chk("model out_valid", 16'(out_valid), 16'(m_ov));
      chk("model in_ready", 16'(in_ready), 16'(m_q.size() != DEPTH));
      chk("model irq_flag", 16'(irq_flag), 16'(m_int));
    end
  end

  task automatic acc(bit i, logic [15:0] a, bit w, logic [15:0] d);
    ioe = i; ADDR_BUS = a; wrmem = w; DO = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    acc(0, 16'h0012, 0, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset DI", DI, 16'h0000);
    chk("reset out_valid", 16'(out_valid), 16'h0);
    chk("reset out_data", out_data, 16'h0000);
    chk("reset in_ready", 16'(in_ready), 16'h1);
    chk("reset irq", 16'(irq_flag), 16'h0);
    rst = 0;

    // RAM
    acc(0, 16'h0012, 1, 16'hA5A5);
    acc(0, 16'h0013, 1, 16'h5A5A);
    acc(0, 16'h0012, 0, 16'h0000);  chk("ram rd 12", DI, 16'hA5A5);
    acc(0, 16'h0012, 1, 16'h1111);  chk("ram rdw old", DI, 16'hA5A5);
    acc(0, 16'h0013, 0, 16'h0000);  chk("ram rd 13", DI, 16'h5A5A);
    acc(0, 16'h0112, 0, 16'h0000);  chk("ram upper ign", DI, 16'h1111);

    // FIFO fill and drain
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1; in_data = 16'(k); idle();
    end
    chk("fifo full rdy", 16'(in_ready), 16'h0);
    in_data = 16'h0005; idle();
    in_valid = 0;
    acc(1, 16'h0002, 0, 0);  chk("status full", DI, 16'h0083);
    for (int k = 1; k <= 4; k++) begin
      idle(); acc(1, 16'h0000, 0, 0); chk("fifo pop", DI, 16'(k));
    end
    idle(); acc(1, 16'h0000, 0, 0);  chk("pop empty", DI, 16'h0000);
    idle(); acc(1, 16'h0002, 0, 0);  chk("status empty", DI, 16'h0000);

    // held access pops once; then push+pop in one cycle
    in_valid = 1; in_data = 16'h0101; idle();
    in_data = 16'h0202; idle();
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      acc(1, 16'h0000, 0, 0); chk("held DI", DI, 16'h0101);
    end
    acc(1, 16'h0002, 0, 0);  chk("held count", DI, 16'h0021);
    idle();
    in_valid = 1; in_data = 16'h0303;
    acc(1, 16'h0000, 0, 0);  chk("push+pop DI", DI, 16'h0202);
    in_valid = 0;
    acc(1, 16'h0002, 0, 0);  chk("push+pop cnt", DI, 16'h0021);
    idle(); acc(1, 16'h0000, 0, 0);  chk("wrap pop", DI, 16'h0303);

    // flush beats a simultaneous push
    in_valid = 1; in_data = 16'h0404; idle(); idle();
    acc(1, 16'h0003, 1, 16'h0004);
    in_valid = 0;
    acc(1, 16'h0002, 0, 0);  chk("flush status", DI, 16'h0000);

    // output overflow
    out_ready = 0;
    idle(); acc(1, 16'h0001, 1, 16'h00AA);  chk("out_valid set", 16'(out_valid), 16'h1);
    idle(); acc(1, 16'h0001, 1, 16'h00BB);  chk("out kept", out_data, 16'h00AA);
    idle(); acc(1, 16'h0002, 0, 0);         chk("status ovf", DI, 16'h000C);
    acc(1, 16'h0001, 0, 0);                 chk("rd out reg", DI, 16'h00AA);
    acc(1, 16'h0003, 1, 16'h0002);
    acc(1, 16'h0002, 0, 0);                 chk("ovf cleared", DI, 16'h0004);
    out_ready = 1; idle();                  chk("out drop", 16'(out_valid), 16'h0);
    out_ready = 0;

    // interrupt
    intreq = 1; idle(); intreq = 0;         chk("irq set", 16'(irq_flag), 16'h1);
    idle(); idle();                         chk("irq sticky", 16'(irq_flag), 16'h1);
    intreq = 1; acc(1, 16'h0003, 1, 16'h0001); chk("irq set wins", 16'(irq_flag), 16'h1);
    intreq = 0; idle();
    acc(1, 16'h0003, 1, 16'h0001);          chk("irq clear", 16'(irq_flag), 16'h0);

    // async reset mid-operation
    in_valid = 1; in_data = 16'h0505; idle(); idle(); idle();
    in_valid = 0;
    idle(); acc(1, 16'h0001, 1, 16'h0077);
    acc(1, 16'h0002, 0, 0);                 chk("pre-rst status", DI, 16'h0065);
    #2 rst = 1;
    #1;
    chk("rst out_valid", 16'(out_valid), 16'h0);
    chk("rst in_ready", 16'(in_ready), 16'h1);
    chk("rst DI", DI, 16'h0000);
    ioe = 0; wrmem = 0; ADDR_BUS = 16'h0012;
    @(posedge clk); #1 rst = 0;
    acc(1, 16'h0002, 0, 0);                 chk("post-rst status", DI, 16'h0000);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
